// File: rtl/pueo_threshold_loader.sv
`default_nettype none
// ============================================================================
// Module   : pueo_threshold_loader
// Purpose  : Snapshots a host-written threshold bank on commit. It streams the
//            bank last beam first into the cascaded threshold chain, then
//            issues one update pulse. Optional macro
//            PUEO_THRESHOLD_LOADER_READBACK_EN adds readback of applied values.
// Revision : 1.0 - initial release
// ============================================================================
module pueo_threshold_loader #(
   parameter int NBEAMS      = 48,
   parameter int UPDATE_GAP  = 1,
   parameter int THRESH_BITS = 18
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        wr_i,
   input  logic [$clog2(NBEAMS)-1:0]   wr_addr_i,
   input  logic                        wr_chan_i,
   input  logic [THRESH_BITS-1:0]      wr_data_i,
   input  logic                        commit_i,
   input  logic [1:0]                  commit_chan_i,
`ifdef PUEO_THRESHOLD_LOADER_READBACK_EN
   input  logic [$clog2(NBEAMS)-1:0]   rd_addr_i,
   input  logic                        rd_chan_i,
   output logic [THRESH_BITS-1:0]      rd_data_o,
`endif
   output logic                        busy_o,
   output logic                        done_o,
   output logic [2*THRESH_BITS-1:0]    thresh_o,
   output logic [1:0]                  thresh_wr_o,
   output logic [1:0]                  thresh_update_o
);

   localparam int c_aw = $clog2(NBEAMS);
   localparam int c_gw = (UPDATE_GAP > 1) ? $clog2(UPDATE_GAP) : 1;
   localparam logic [c_aw:0] c_nbeams_ext = (c_aw + 1)'(NBEAMS);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_GAP    = 2'd2,
      S_UPDATE = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic [c_aw-1:0]        r_cnt;
   logic [c_gw-1:0]        r_gap_cnt;
   logic [1:0]             r_mask;
   logic                   r_pend_flag;
   logic [1:0]             r_pend_mask;

   logic [THRESH_BITS-1:0] r_pend      [NBEAMS][2];
   logic [THRESH_BITS-1:0] r_snap      [NBEAMS][2];
   logic [THRESH_BITS-1:0] w_pend_next [NBEAMS][2];

   logic                   w_wr_ok;
   logic                   w_commit_valid;
   logic                   w_accept;
   logic [1:0]             w_accept_mask;

   assign w_wr_ok        = wr_i && ({1'b0, wr_addr_i} < c_nbeams_ext);
   assign w_commit_valid = commit_i && (commit_chan_i != 2'b00);
   // A queued commit is taken in the first idle cycle, merged with any new one
   assign w_accept       = (r_state == S_IDLE) && (r_pend_flag || w_commit_valid);
   assign w_accept_mask  = r_pend_mask | (commit_i ? commit_chan_i : 2'b00);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_next_state = S_LOAD;
         S_LOAD:   if (r_cnt == '0) w_next_state = S_GAP;
         S_GAP:    if (r_gap_cnt == '0) w_next_state = S_UPDATE;
         S_UPDATE: w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // Same-cycle host write lands in the snapshot as well
   always_comb begin
      w_pend_next = r_pend;
      if (w_wr_ok) w_pend_next[wr_addr_i][wr_chan_i] = wr_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int b = 0; b < NBEAMS; b++) begin
            for (int c = 0; c < 2; c++) begin
               r_pend[b][c] <= '0;
               r_snap[b][c] <= '0;
            end
         end
      end else begin
         r_pend <= w_pend_next;
         if (w_accept) r_snap <= w_pend_next;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state         <= S_IDLE;
         r_cnt           <= '0;
         r_gap_cnt       <= '0;
         r_mask          <= 2'b00;
         r_pend_flag     <= 1'b0;
         r_pend_mask     <= 2'b00;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         thresh_o        <= '0;
         thresh_wr_o     <= 2'b00;
         thresh_update_o <= 2'b00;
      end else begin
         r_state         <= w_next_state;
         busy_o          <= (r_state != S_IDLE);
         done_o          <= (thresh_update_o != 2'b00);
         thresh_wr_o     <= (r_state == S_LOAD)   ? r_mask : 2'b00;
         thresh_update_o <= (r_state == S_UPDATE) ? r_mask : 2'b00;

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cnt  <= c_aw'(NBEAMS - 1);
                  r_mask <= w_accept_mask;
               end
            end
            S_LOAD: begin
               thresh_o <= {r_snap[r_cnt][1], r_snap[r_cnt][0]};
               r_cnt    <= r_cnt - 1'b1;
               if (r_cnt == '0) r_gap_cnt <= c_gw'(UPDATE_GAP - 1);
            end
            S_GAP: begin
               r_gap_cnt <= r_gap_cnt - 1'b1;
            end
            default: ;
         endcase

         if (w_accept) begin
            r_pend_flag <= 1'b0;
            r_pend_mask <= 2'b00;
         end else if ((r_state != S_IDLE) && w_commit_valid) begin
            r_pend_flag <= 1'b1;
            r_pend_mask <= r_pend_mask | commit_chan_i;
         end
      end
   end

`ifdef PUEO_THRESHOLD_LOADER_READBACK_EN
   logic [THRESH_BITS-1:0] r_active [NBEAMS][2];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int b = 0; b < NBEAMS; b++) begin
            for (int c = 0; c < 2; c++) begin
               r_active[b][c] <= '0;
            end
         end
         rd_data_o <= '0;
      end else begin
         if (r_state == S_UPDATE) begin
            for (int b = 0; b < NBEAMS; b++) begin
               for (int c = 0; c < 2; c++) begin
                  if (r_mask[c]) r_active[b][c] <= r_snap[b][c];
               end
            end
         end
         rd_data_o <= ({1'b0, rd_addr_i} < c_nbeams_ext) ? r_active[rd_addr_i][rd_chan_i] : '0;
      end
   end
`endif

endmodule
`default_nettype wire

// File: doc/pueo_threshold_loader.md
Name: pueo_threshold_loader

Overview:
- Sequencer upstream of dual_pueo_threshold_v2; drives its thresh_i / thresh_wr_i / thresh_update_i.
- Host writes per-beam, per-channel thresholds into a pending register bank at any time. A commit snapshots the bank, then streams it into the cascaded threshold DSP chain, last beam first.
- After a fixed gap, the block pulses update so all beams switch to the new thresholds at once.

Parameters:
- NBEAMS, 48, beams per channel; number of cascaded threshold stages.
- UPDATE_GAP, 1, idle cycles between last thresh_wr_o cycle and the thresh_update_o pulse (must be >=1).
- THRESH_BITS, 18, threshold word width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- wr_i  in  1  host write strobe to pending bank
- wr_addr_i  in  $clog2(NBEAMS)  beam index
- wr_chan_i  in  1  channel select (0=A, 1=B)
- wr_data_i  in  THRESH_BITS  threshold value
- commit_i  in  1  request load of pending bank (single-cycle pulse)
- commit_chan_i  in  2  per-channel enable for this commit
- busy_o  out  1  load sequence in progress
- done_o  out  1  one-cycle pulse after update issued
- thresh_o  out  2*THRESH_BITS  {chB,chA} threshold stream
- thresh_wr_o  out  2  per-channel cascade write enable
- thresh_update_o  out  2  per-channel update pulse

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low (rst_ni).
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Pending flag is clear.
  - Pending bank and snapshot bank are 0.
- Pending bank:
  - wr_i writes wr_data_i to [wr_addr_i][wr_chan_i] at the clock edge.
  - wr_addr_i >= NBEAMS is ignored.
  - Writes are accepted in every state.
- Snapshot:
  - When a commit is accepted, the pending bank is copied to the snapshot bank.
  - A wr_i in the same cycle as an accepted commit_i is included in the snapshot (write-through).
  - Writes made during LOAD, GAP or UPDATE affect only the next commit.
- FSM states: IDLE -> LOAD -> GAP -> UPDATE -> IDLE.
  - IDLE: on commit_i with commit_chan_i != 0, take the snapshot, set beam counter = NBEAMS-1, go to LOAD. A commit with commit_chan_i == 0 is ignored.
  - LOAD: NBEAMS cycles.
    - Each cycle, thresh_o = snapshot[cnt] for both channels and thresh_wr_o = latched chan mask.
    - cnt decrements; at cnt==0 go to GAP.
  - GAP: UPDATE_GAP cycles. thresh_wr_o = 0; thresh_o holds beam 0 data.
  - UPDATE: one cycle with thresh_update_o = chan mask. Go to IDLE; done_o = 1 on the next cycle.
- busy_o = 1 in LOAD, GAP and UPDATE.
- Latency: with commit_i sampled at edge 0:
  - beam NBEAMS-1 appears on edge 1;
  - thresh_update_o is high on edge 1+NBEAMS+UPDATE_GAP;
  - done_o is high on the edge after that.
- Commit while busy:
  - Set the pending flag and OR commit_chan_i into the pending mask. The pending flag is one deep; further commits merge into it.
  - In the cycle done_o pulses, the pending commit is accepted as if issued in IDLE, with a fresh snapshot. LOAD begins the next cycle.
  - The pending flag and mask clear on acceptance.
- Masked channel: thresh_wr_o and thresh_update_o bits stay 0. thresh_o still carries data for both channels.
- Reset mid-sequence:
  - All outputs are immediately 0 (async). No partial update pulse is ever issued.
  - The pending flag is cleared.
  - The downstream chain keeps its old active thresholds.

Optional Feature:
- Macro: PUEO_THRESHOLD_LOADER_READBACK_EN.
- With the macro defined:
  - Adds ports rd_addr_i (in, $clog2(NBEAMS)), rd_chan_i (in, 1) and rd_data_o (out, THRESH_BITS).
  - rd_data_o returns, one cycle after the address, the last value actually applied by an UPDATE for that beam/channel.
  - A separate active bank is copied from the snapshot for the masked channels at UPDATE.
  - The active bank resets to 0.
- Without the macro: none of these ports exist and no active bank is built.

Test Plan:
- Basic load, NBEAMS=2, UPDATE_GAP=1:
  - Stimulus: write beam1 A=10, B=20 and beam0 A=200, B=200; commit with chan 2'b11 at edge 0.
  - Edge 1: thresh=(20,10), wr=11.
  - Edge 2: thresh=(200,200), wr=11.
  - Edge 3: wr=00.
  - Edge 4: update=11.
  - Edge 5: done=1.
  - busy is high on edges 1-4.
- Channel mask:
  - Stimulus: same data, commit_chan_i=2'b10.
  - Response: thresh_wr_o and thresh_update_o show only bit1. Bit0 stays 0 throughout.
- Write during load:
  - Stimulus: rewrite beam1 A=55 on edge 1 of a load.
  - Response: the current stream still shows 10. A second commit streams 55 first.
- Queued commits:
  - Stimulus: commit 01 at edge 0; commits 10 and 01 during busy.
  - Response: after done on edge 5, a second sequence starts. Its wr/update mask is 11 and its thresh_wr_o begins on edge 6.
- Reset mid-LOAD:
  - Stimulus: deassert rst_ni at edge 1.5.
  - Response: all outputs are 0 immediately. No update pulse follows. A pending commit is discarded. After release, the block is idle until the next commit.
- Readback (macro defined):
  - After test 1, beam1 chan1 reads 20.
  - Before any update, reads return 0.
  - After a masked 01 commit of new data, channel B readback is unchanged.
